// File: rtl/aes_pkg.sv
// Shared AES round-key constants, FSM state type and beat payload for the round-key streamer.
package aes_pkg;

  localparam int unsigned AES_NR       = 10;
  localparam int unsigned AES_NUM_RK   = 11;
  localparam int unsigned AES_KEY_W    = 128;
  localparam int unsigned AES_BANK_W   = AES_NR * AES_KEY_W;
  localparam int unsigned RK_IDX_W     = 4;
  localparam int unsigned STREAM_CNT_W = 8;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } rks_state_t;

  typedef struct packed {
    logic [AES_KEY_W-1:0] data;
    logic [RK_IDX_W-1:0]  index;
    logic                 last;
  } rk_beat_t;

  // Final round index of a stream: 10 going forward, 0 going in reverse.
  function automatic logic rk_is_last(input logic [RK_IDX_W-1:0] idx, input logic rev);
    if (rev) begin
      return (idx == '0);
    end
    return (idx == RK_IDX_W'(AES_NR));
  endfunction

  // Next round index in stream order, saturating so the counter never leaves 0..10.
  function automatic logic [RK_IDX_W-1:0] rk_step(input logic [RK_IDX_W-1:0] idx, input logic rev);
    if (rev) begin
      return (idx == '0) ? '0 : idx - RK_IDX_W'(1);
    end
    return (idx >= RK_IDX_W'(AES_NR)) ? RK_IDX_W'(AES_NR) : idx + RK_IDX_W'(1);
  endfunction

endpackage

// File: rtl/round_key_bank.sv
// 11 x 128 round-key store: all entries written together, one entry read by round index.
module round_key_bank
  import aes_pkg::*;
(
  input  logic                  clk,
  input  logic                  i_wr_en,
  input  logic [AES_KEY_W-1:0]  i_key0,
  input  logic [AES_BANK_W-1:0] i_key_bank,
  input  logic [RK_IDX_W-1:0]   i_rd_idx,
  output logic [AES_KEY_W-1:0]  o_rd_data_c
);

  logic [AES_KEY_W-1:0] r_mem [AES_NUM_RK];

  // Capture the cipher key and the ten expanded keys; contents are not reset.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[0] <= i_key0;
      for (int unsigned k = 1; k < AES_NUM_RK; k++) begin
        r_mem[k] <= i_key_bank[(k-1)*AES_KEY_W +: AES_KEY_W];
      end
    end
  end

  // Read mux by round index; unused indices return zero.
  always_comb begin
    o_rd_data_c = '0;
    for (int unsigned k = 0; k < AES_NUM_RK; k++) begin
      if (i_rd_idx == RK_IDX_W'(k)) begin
        o_rd_data_c = r_mem[k];
      end
    end
  end

endmodule

// File: rtl/round_key_stream.sv
// Streams the 11 AES-128 round keys over a valid/ready interface.
// Optional macro ROUND_KEY_DECRYPT_EN adds port dir for reverse (10..0) order.
module round_key_stream
  import aes_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [AES_KEY_W-1:0]    aes_key,
  input  logic [AES_BANK_W-1:0]   key_bank,
`ifdef ROUND_KEY_DECRYPT_EN
  input  logic                    dir,
`endif
  input  logic                    flush,
  input  logic                    rk_ready,
  output logic                    rk_valid,
  output logic [AES_KEY_W-1:0]    rk_data,
  output logic [RK_IDX_W-1:0]     rk_index,
  output logic                    rk_last,
  output logic                    busy,
  output logic [STREAM_CNT_W-1:0] stream_count
);

  rks_state_t              r_state;
  logic                    r_valid;
  rk_beat_t                r_beat;
  logic                    r_busy;
  logic [STREAM_CNT_W-1:0] r_count;
  logic                    r_rev;

  rks_state_t              w_state_nxt;
  logic                    w_valid_nxt;
  rk_beat_t                w_beat_nxt;
  logic                    w_busy_nxt;
  logic [STREAM_CNT_W-1:0] w_count_nxt;
  logic                    w_rev_nxt;
  logic                    w_wr_en;
  logic [RK_IDX_W-1:0]     w_rd_idx;
  logic [AES_KEY_W-1:0]    w_rd_data;
  logic                    w_dir;

`ifdef ROUND_KEY_DECRYPT_EN
  assign w_dir = dir;
`else
  assign w_dir = 1'b0;
`endif

  round_key_bank u_bank (
    .clk         (clk),
    .i_wr_en     (w_wr_en),
    .i_key0      (aes_key),
    .i_key_bank  (key_bank),
    .i_rd_idx    (w_rd_idx),
    .o_rd_data_c (w_rd_data)
  );

  // Next-state and next-output logic; the first beat bypasses the store from the inputs.
  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_valid;
    w_beat_nxt  = r_beat;
    w_busy_nxt  = r_busy;
    w_count_nxt = r_count;
    w_rev_nxt   = r_rev;
    w_wr_en     = 1'b0;
    w_rd_idx    = rk_step(r_beat.index, r_rev);

    case (r_state)
      ST_IDLE: begin
        if (load) begin
          w_wr_en          = 1'b1;
          w_state_nxt      = ST_STREAM;
          w_valid_nxt      = 1'b1;
          w_busy_nxt       = 1'b1;
          w_rev_nxt        = w_dir;
          w_beat_nxt.index = w_dir ? RK_IDX_W'(AES_NR) : '0;
          w_beat_nxt.data  = w_dir ? key_bank[AES_BANK_W-1 -: AES_KEY_W] : aes_key;
          w_beat_nxt.last  = 1'b0;
        end
      end

      ST_STREAM: begin
        if (flush) begin
          w_state_nxt     = ST_IDLE;
          w_valid_nxt     = 1'b0;
          w_busy_nxt      = 1'b0;
          w_beat_nxt.last = 1'b0;
        end else if (r_valid && rk_ready) begin
          if (r_beat.last) begin
            w_state_nxt     = ST_IDLE;
            w_valid_nxt     = 1'b0;
            w_busy_nxt      = 1'b0;
            w_beat_nxt.last = 1'b0;
            w_count_nxt     = r_count + STREAM_CNT_W'(1);
          end else begin
            w_beat_nxt.index = w_rd_idx;
            w_beat_nxt.data  = w_rd_data;
            w_beat_nxt.last  = rk_is_last(w_rd_idx, r_rev);
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_beat  <= '0;
      r_busy  <= 1'b0;
      r_count <= '0;
      r_rev   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_valid_nxt;
      r_beat  <= w_beat_nxt;
      r_busy  <= w_busy_nxt;
      r_count <= w_count_nxt;
      r_rev   <= w_rev_nxt;
    end
  end

  assign rk_valid     = r_valid;
  assign rk_data      = r_beat.data;
  assign rk_index     = r_beat.index;
  assign rk_last      = r_beat.last;
  assign busy         = r_busy;
  assign stream_count = r_count;

endmodule

// File: tb/tb_round_key_stream.sv
// Scoreboard bench for round_key_stream using the FIPS-197 AES-128 example key schedule.
module tb_round_key_stream;

  typedef struct packed {
    logic [127:0] data;
    logic [3:0]   idx;
    logic         last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load;
  logic          flush;
  logic          rk_ready;
`ifdef ROUND_KEY_DECRYPT_EN
  logic          dir;
`endif
  logic [127:0]  aes_key;
  logic [1279:0] key_bank;
  logic          rk_valid;
  logic [127:0]  rk_data;
  logic [3:0]    rk_index;
  logic          rk_last;
  logic          busy;
  logic [7:0]    stream_count;

  logic [127:0]  rk [0:10];
  logic [1279:0] kb;
  exp_t          exp_q [$];
  int            n_cmp = 0;
  int            n_err = 0;

  always #5 clk = ~clk;

  round_key_stream dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (load),
    .aes_key      (aes_key),
    .key_bank     (key_bank),
`ifdef ROUND_KEY_DECRYPT_EN
    .dir          (dir),
`endif
    .flush        (flush),
    .rk_ready     (rk_ready),
    .rk_valid     (rk_valid),
    .rk_data      (rk_data),
    .rk_index     (rk_index),
    .rk_last      (rk_last),
    .busy         (busy),
    .stream_count (stream_count)
  );

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue the beats expected from a stream, in transfer order.
  task automatic push_stream(input bit rev, input int n_beats);
    for (int i = 0; i < n_beats; i++) begin
      int   idx;
      exp_t e;
      idx    = rev ? (10 - i) : i;
      e.data = rk[idx];
      e.idx  = 4'(idx);
      e.last = rev ? (idx == 0) : (idx == 10);
      exp_q.push_back(e);
    end
  endtask

  // Pops one expectation per transfer and checks that stalled outputs hold.
  task automatic monitor();
    exp_t         e;
    bit           stall_prev = 1'b0;
    logic [127:0] held_d = '0;
    logic [3:0]   held_i = '0;
    logic         held_l = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && !flush && rk_valid && rk_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL beat_unexpected: actual index=%0d required no beat", rk_index);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", rk_data, e.data);
          chk("beat_index", 128'(rk_index), 128'(e.idx));
          chk("beat_last", 128'(rk_last), 128'(e.last));
        end
      end
      if (stall_prev && rst_n && rk_valid) begin
        chk("hold_data", rk_data, held_d);
        chk("hold_index", 128'(rk_index), 128'(held_i));
        chk("hold_last", 128'(rk_last), 128'(held_l));
      end
      stall_prev = rst_n && !flush && rk_valid && !rk_ready;
      held_d     = rk_data;
      held_i     = rk_index;
      held_l     = rk_last;
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_valid"}, 128'(rk_valid), 128'(0));
    chk({tag, "_data"}, rk_data, 128'(0));
    chk({tag, "_index"}, 128'(rk_index), 128'(0));
    chk({tag, "_last"}, 128'(rk_last), 128'(0));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_count"}, 128'(stream_count), 128'(0));
  endtask

  // Drive rk_ready until the stream ends; a load pulse with junk keys is issued mid-stream.
  task automatic run_stream(input bit bp);
    int n = 0;
    while (rk_valid && n < 80) begin
      rk_ready = bp ? (n % 3 == 0) : 1'b1;
      if (n == 2) begin
        load     = 1'b1;
        aes_key  = '0;
        key_bank = '1;
      end else begin
        load     = 1'b0;
        aes_key  = rk[0];
        key_bank = kb;
      end
      tick();
      n++;
    end
    load     = 1'b0;
    aes_key  = rk[0];
    key_bank = kb;
    chk("stream_end", 128'(rk_valid), 128'(0));
  endtask

  task automatic run_to_index(input int target);
    int n = 0;
    rk_ready = 1'b1;
    while (rk_index != 4'(target) && n < 20) begin
      tick();
      n++;
    end
    chk("reach_index", 128'(rk_index), 128'(target));
  endtask

  task automatic start_load();
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  initial begin
    rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    kb = {rk[10], rk[9], rk[8], rk[7], rk[6], rk[5], rk[4], rk[3], rk[2], rk[1]};

    rst_n    = 1'b0;
    load     = 1'b0;
    flush    = 1'b0;
    rk_ready = 1'b0;
    aes_key  = rk[0];
    key_bank = kb;
`ifdef ROUND_KEY_DECRYPT_EN
    dir      = 1'b0;
`endif

    fork
      monitor();
    join_none

    tick();
    tick();
    check_reset("reset");
    rst_n = 1'b1;

    // Forward stream at full rate.
    push_stream(1'b0, 11);
    rk_ready = 1'b1;
    start_load();
    chk("first_valid", 128'(rk_valid), 128'(1));
    chk("first_index", 128'(rk_index), 128'(0));
    chk("first_busy", 128'(busy), 128'(1));
    run_stream(1'b0);
    chk("fwd_count", 128'(stream_count), 128'(1));
    chk("fwd_busy", 128'(busy), 128'(0));

    // Back-to-back load in the idle cycle, then backpressure 1,0,0,1,...
    push_stream(1'b0, 11);
    start_load();
    chk("b2b_valid", 128'(rk_valid), 128'(1));
    chk("b2b_index", 128'(rk_index), 128'(0));
    run_stream(1'b1);
    chk("bp_count", 128'(stream_count), 128'(2));
    chk("bp_queue", 128'(exp_q.size()), 128'(0));

    // Flush at index 4 with rk_ready high: beat 4 must not transfer.
    push_stream(1'b0, 4);
    start_load();
    run_to_index(4);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_valid", 128'(rk_valid), 128'(0));
    chk("flush_busy", 128'(busy), 128'(0));
    chk("flush_count", 128'(stream_count), 128'(2));
    chk("flush_queue", 128'(exp_q.size()), 128'(0));
    push_stream(1'b0, 11);
    start_load();
    chk("restart_valid", 128'(rk_valid), 128'(1));
    chk("restart_index", 128'(rk_index), 128'(0));
    chk("restart_data", rk_data, rk[0]);
    run_stream(1'b0);
    chk("restart_count", 128'(stream_count), 128'(3));

    // Reset while streaming at index 6.
    push_stream(1'b0, 6);
    start_load();
    run_to_index(6);
    rst_n = 1'b0;
    tick();
    check_reset("midrst");
    rst_n = 1'b1;
    chk("midrst_queue", 128'(exp_q.size()), 128'(0));

    // 256 complete streams wrap the counter back to zero.
    for (int s = 0; s < 256; s++) begin
      push_stream(1'b0, 11);
      rk_ready = 1'b1;
      start_load();
      run_stream(1'b0);
      if (s == 254) begin
        chk("count_255", 128'(stream_count), 128'(255));
      end
    end
    chk("count_wrap", 128'(stream_count), 128'(0));

`ifdef ROUND_KEY_DECRYPT_EN
    // Reverse order 10..0.
    push_stream(1'b1, 11);
    dir = 1'b1;
    start_load();
    dir = 1'b0;
    chk("rev_first_index", 128'(rk_index), 128'(10));
    chk("rev_first_data", rk_data, rk[10]);
    run_stream(1'b0);
    chk("rev_count", 128'(stream_count), 128'(1));
`endif

    tick();
    chk("final_queue", 128'(exp_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
